sync_fifo: RTL and testbench

SYNC_FIFO -- requirements
Module: sync_fifo

---
 rtl/sync_fifo_pkg.sv | 12 +
 rtl/sync_fifo_if.sv | 35 +++
 rtl/sync_fifo_ram.sv | 26 ++
 rtl/sync_fifo.sv | 100 ++++++++++
 tb/tb_sync_fifo.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the synchronous FIFO: read-mode encodings and default widths.
package sync_fifo_pkg;

  localparam int unsigned DATA_SIZE_DEF = 8;
  localparam int unsigned ADDR_SIZE_DEF = 3;

  typedef enum logic {
    MODE_REGISTERED = 1'b0,
    MODE_FWFT       = 1'b1
  } read_mode_e;

endpackage

// File: rtl/sync_fifo_if.sv
// Write/read handshake and status bundle of sync_fifo; master = user side, slave = FIFO side.
interface sync_fifo_if
  import sync_fifo_pkg::*;
#(
  parameter int unsigned data_Size    = DATA_SIZE_DEF,
  parameter int unsigned address_Size = ADDR_SIZE_DEF
);

  logic                    w_Enable;
  logic [data_Size-1:0]    write_Data;
  logic                    r_Enable;
  logic                    err_Clear;
  logic [data_Size-1:0]    read_Data;
  logic                    read_Valid;
  logic                    fifo_Full;
  logic                    fifo_Empty;
  logic                    almost_Full;
  logic                    almost_Empty;
  logic [address_Size:0]   fill_Count;
  logic                    overflow;
  logic                    underflow;

  modport master (
    output w_Enable, write_Data, r_Enable, err_Clear,
    input  read_Data, read_Valid, fifo_Full, fifo_Empty,
           almost_Full, almost_Empty, fill_Count, overflow, underflow
  );

  modport slave (
    input  w_Enable, write_Data, r_Enable, err_Clear,
    output read_Data, read_Valid, fifo_Full, fifo_Empty,
           almost_Full, almost_Empty, fill_Count, overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_ram.sv
// FIFO storage array: one write port gated by the accepted-write strobe, asynchronous read, no reset.
module fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int unsigned data_Size    = DATA_SIZE_DEF,
  parameter int unsigned address_Size = ADDR_SIZE_DEF
) (
  input  logic                    i_clk,
  input  logic                    i_we,
  input  logic [address_Size-1:0] i_waddr,
  input  logic [data_Size-1:0]    i_wdata,
  input  logic [address_Size-1:0] i_raddr,
  output logic [data_Size-1:0]    o_rdata
);

  logic [data_Size-1:0] r_mem [0:(1<<address_Size)-1];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered status flags, sticky overflow/underflow and
// selectable registered or first-word-fall-through read port.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int unsigned data_Size        = DATA_SIZE_DEF,
  parameter int unsigned address_Size     = ADDR_SIZE_DEF,
  parameter int unsigned almost_Full_Thr  = 6,
  parameter int unsigned almost_Empty_Thr = 2,
  parameter bit          fwft_Mode        = 1'b0
) (
  input  logic         Clk,
  input  logic         Rst_n,
  sync_fifo_if.slave   bus
);

  localparam int unsigned PW   = address_Size + 1;
  localparam bit          FWFT = (read_mode_e'(fwft_Mode) == MODE_FWFT);

  logic [PW-1:0]        r_wr_ptr, r_rd_ptr, r_count;
  logic [PW-1:0]        w_wr_ptr_nxt, w_rd_ptr_nxt, w_count_nxt;
  logic                 r_full, r_empty, r_afull, r_aempty;
  logic                 r_ovf, r_udf, r_rd_valid;
  logic [data_Size-1:0] r_rd_data, w_ram_rdata;
  logic                 w_wr_acc, w_rd_acc, w_wr_rej, w_rd_rej;

  // Acceptance uses the registered flags, so a read+write on a full FIFO
  // drops the write and a read+write on an empty FIFO drops the read.
  always_comb begin
    w_wr_acc     = bus.w_Enable & ~r_full;
    w_rd_acc     = bus.r_Enable & ~r_empty;
    w_wr_rej     = bus.w_Enable & r_full;
    w_rd_rej     = bus.r_Enable & r_empty;
    w_wr_ptr_nxt = r_wr_ptr + PW'(w_wr_acc);
    w_rd_ptr_nxt = r_rd_ptr + PW'(w_rd_acc);
    w_count_nxt  = r_count;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_nxt = r_count + PW'(1);
      2'b01:   w_count_nxt = r_count - PW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_afull    <= 1'b0;
      r_aempty   <= 1'b1;
      r_ovf      <= 1'b0;
      r_udf      <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_count    <= w_count_nxt;
      r_full     <= (w_wr_ptr_nxt[address_Size] != w_rd_ptr_nxt[address_Size]) &&
                    (w_wr_ptr_nxt[address_Size-1:0] == w_rd_ptr_nxt[address_Size-1:0]);
      r_empty    <= (w_wr_ptr_nxt == w_rd_ptr_nxt);
      r_afull    <= (32'(w_count_nxt) >= almost_Full_Thr);
      r_aempty   <= (32'(w_count_nxt) <= almost_Empty_Thr);
      // A new error in the same cycle as err_Clear keeps the flag set.
      r_ovf      <= w_wr_rej | (r_ovf & ~bus.err_Clear);
      r_udf      <= w_rd_rej | (r_udf & ~bus.err_Clear);
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_rd_data <= w_ram_rdata;
      end
    end
  end

  fifo_ram #(
    .data_Size    (data_Size),
    .address_Size (address_Size)
  ) u_ram (
    .i_clk   (Clk),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr[address_Size-1:0]),
    .i_wdata (bus.write_Data),
    .i_raddr (r_rd_ptr[address_Size-1:0]),
    .o_rdata (w_ram_rdata)
  );

  // In FWFT mode the head word is shown directly; forced to zero while empty
  // so stale array contents never reach read_Data.
  assign bus.read_Valid   = FWFT ? ~r_empty : r_rd_valid;
  assign bus.read_Data    = FWFT ? (r_empty ? '0 : w_ram_rdata) : r_rd_data;
  assign bus.fifo_Full    = r_full;
  assign bus.fifo_Empty   = r_empty;
  assign bus.almost_Full  = r_afull;
  assign bus.almost_Empty = r_aempty;
  assign bus.fill_Count   = r_count;
  assign bus.overflow     = r_ovf;
  assign bus.underflow    = r_udf;

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: a registered-read and an FWFT instance driven with identical directed stimulus.
module tb_sync_fifo;
  import sync_fifo_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sync_fifo_if #(.data_Size(8), .address_Size(3)) if0 ();
  sync_fifo_if #(.data_Size(8), .address_Size(3)) if1 ();

  sync_fifo #(.data_Size(8), .address_Size(3), .almost_Full_Thr(6),
              .almost_Empty_Thr(2), .fwft_Mode(MODE_REGISTERED))
    dut0 (.Clk(clk), .Rst_n(rst_n), .bus(if0));

  sync_fifo #(.data_Size(8), .address_Size(3), .almost_Full_Thr(6),
              .almost_Empty_Thr(2), .fwft_Mode(MODE_FWFT))
    dut1 (.Clk(clk), .Rst_n(rst_n), .bus(if1));

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] mq[$];    // reference FIFO contents
  logic [7:0] exp0[$];  // words owed on dut0 read_Valid
  logic [7:0] exp1[$];  // words owed on dut1 pops
  bit         exp_rv0 = 1'b0;
  bit         m_ov = 1'b0;
  bit         m_uf = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_status();
    int n;
    n = mq.size();
    chk("fill_Count",      int'(if0.fill_Count),   n);
    chk("fifo_Full",       int'(if0.fifo_Full),    int'(n == 8));
    chk("fifo_Empty",      int'(if0.fifo_Empty),   int'(n == 0));
    chk("almost_Full",     int'(if0.almost_Full),  int'(n >= 6));
    chk("almost_Empty",    int'(if0.almost_Empty), int'(n <= 2));
    chk("overflow",        int'(if0.overflow),     int'(m_ov));
    chk("underflow",       int'(if0.underflow),    int'(m_uf));
    chk("fwft_fill_Count", int'(if1.fill_Count),   n);
    chk("fwft_overflow",   int'(if1.overflow),     int'(m_ov));
    chk("fwft_underflow",  int'(if1.underflow),    int'(m_uf));
  endtask

  // One clock of stimulus applied to both instances; called just after a rising edge.
  task automatic cyc(input bit we, input logic [7:0] wd, input bit re,
                     input bit clr = 1'b0, input bit rst = 1'b0);
    bit wacc, racc, wrej, rrej;
    if0.w_Enable = we;  if0.write_Data = wd;  if0.r_Enable = re;  if0.err_Clear = clr;
    if1.w_Enable = we;  if1.write_Data = wd;  if1.r_Enable = re;  if1.err_Clear = clr;
    rst_n = ~rst;
    wacc = we && (mq.size() < 8);
    wrej = we && (mq.size() == 8);
    racc = re && (mq.size() != 0);
    rrej = re && (mq.size() == 0);
    if (!rst && racc) exp1.push_back(mq[0]);
    @(posedge clk);
    #1;
    if (rst) begin
      mq.delete();
      exp0.delete();
      exp1.delete();
      m_ov = 1'b0;
      m_uf = 1'b0;
      exp_rv0 = 1'b0;
    end else begin
      if (racc) exp0.push_back(mq.pop_front());
      if (wacc) mq.push_back(wd);
      m_ov = wrej | (m_ov & ~clr);
      m_uf = rrej | (m_uf & ~clr);
      exp_rv0 = racc;
    end
    chk_status();
  endtask

  // Monitor: compares read outputs against the scoreboard queues away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("read_Valid", int'(if0.read_Valid), int'(exp_rv0));
      if (if0.read_Valid) begin
        if (exp0.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL read_Data: unexpected word 0x%0h, none owed", if0.read_Data);
        end else begin
          chk("read_Data", int'(if0.read_Data), int'(exp0.pop_front()));
        end
      end
      chk("fwft_read_Valid", int'(if1.read_Valid), int'(mq.size() != 0));
      if (if1.read_Valid && if1.r_Enable) begin
        if (exp1.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL fwft_read_Data: unexpected pop of 0x%0h, none owed", if1.read_Data);
        end else begin
          chk("fwft_read_Data", int'(if1.read_Data), int'(exp1.pop_front()));
        end
      end
    end
  end

  initial begin
    cyc(0, 8'h00, 0, 0, 1);
    cyc(0, 8'h00, 0, 0, 1);
    chk("reset_read_Data",      int'(if0.read_Data),  0);
    chk("reset_read_Valid",     int'(if0.read_Valid), 0);
    chk("reset_fwft_read_Data", int'(if1.read_Data),  0);

    // Fill with 0x01..0x08, then a ninth write must be rejected.
    for (int i = 1; i <= 8; i++) cyc(1, 8'(i), 0);
    chk("full_count_8", int'(if0.fill_Count), 8);
    cyc(1, 8'h09, 0);
    chk("overflow_on_9th", int'(if0.overflow), 1);

    // Drain: 0x01..0x08 in order, then a ninth read flags underflow.
    cyc(0, 8'h00, 0, 1);
    for (int i = 0; i < 8; i++) cyc(0, 8'h00, 1);
    cyc(0, 8'h00, 0);
    cyc(0, 8'h00, 1);
    chk("underflow_on_9th", int'(if0.underflow), 1);
    cyc(0, 8'h00, 1, 1);
    chk("clear_vs_new_error", int'(if0.underflow), 1);
    cyc(0, 8'h00, 0, 1);

    // Read+write while full: write of 0xAA dropped, overflow set.
    for (int i = 0; i < 8; i++) cyc(1, 8'h11 + 8'(i), 0);
    cyc(1, 8'hAA, 1);
    chk("rw_full_count", int'(if0.fill_Count), 7);
    for (int i = 0; i < 7; i++) cyc(0, 8'h00, 1);
    cyc(0, 8'h00, 0, 1);

    // Read+write while empty: write taken, read rejected.
    cyc(1, 8'h3C, 1);
    chk("rw_empty_count", int'(if0.fill_Count), 1);
    cyc(0, 8'h00, 1, 1);
    cyc(0, 8'h00, 0, 1);

    // First-word-fall-through on a single write.
    cyc(1, 8'h5C, 0);
    chk("fwft_valid_after_write", int'(if1.read_Valid), 1);
    chk("fwft_data_after_write",  int'(if1.read_Data),  8'h5C);
    cyc(0, 8'h00, 1);
    chk("fwft_empty_after_pop", int'(if1.fifo_Empty), 1);
    cyc(0, 8'h00, 0);

    // Pointer wrap with occupancy held at 3.
    for (int i = 0; i < 3; i++) cyc(1, 8'h30 + 8'(i), 0);
    for (int i = 0; i < 20; i++) cyc(1, 8'h40 + 8'(i), 1);
    chk("wrap_count", int'(if0.fill_Count), 3);
    for (int i = 0; i < 3; i++) cyc(0, 8'h00, 1);
    cyc(0, 8'h00, 0);

    // Reset mid-traffic at count 5 with overflow set.
    for (int i = 0; i < 8; i++) cyc(1, 8'h60 + 8'(i), 0);
    cyc(1, 8'hEE, 0);
    for (int i = 0; i < 3; i++) cyc(0, 8'h00, 1);
    cyc(0, 8'h00, 0);
    chk("pre_reset_count", int'(if0.fill_Count), 5);
    cyc(1, 8'hDD, 1, 0, 1);
    chk("post_reset_count",    int'(if0.fill_Count), 0);
    chk("post_reset_overflow", int'(if0.overflow),   0);
    chk("post_reset_empty",    int'(if0.fifo_Empty), 1);
    cyc(1, 8'h77, 0);
    cyc(0, 8'h00, 1);
    cyc(0, 8'h00, 0);
    cyc(0, 8'h00, 0);

    chk("pending_reads_mode0", exp0.size(), 0);
    chk("pending_reads_fwft",  exp1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
